riscv_instruction_encoder: RTL and testbench
============================================

// Module: riscv_instruction_encoder
// PURPOSE
//  Inverse of the decode helpers: packs a decoded_instruction_t into a 32-bit RV32I word.
//  Program-loader front end: a test driver streams decoded instructions in.
//  Encoded words leave with sequential instruction-memory addresses through a FIFO.
//  Unencodable instructions are consumed, dropped and flagged.
// PARAMETERS
//  BASE_ADDRESS  32'h0000_0000  address given to the first word after reset/flush
//  FIFO_DEPTH    4              output FIFO entries (power of 2, >=2)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  flush           in   1   sync: empty FIFO, next address := BASE_ADDRESS
//  in_valid        in   1   in_instruction valid
//  in_ready        out  1   encoder can accept
//  in_instruction  in   64  decoded_instruction_t
//  out_valid       out  1   FIFO head valid
//  out_ready       in   1   consumer takes head
//  out_address     out  32  instruction-memory byte address of head
//  out_word        out  32  encoded instruction of head
//  error           out  1   1-cycle pulse: accepted instruction was unencodable
//  error_count     out  8   saturating count of errors
// BEHAVIOUR
//  Reset: FIFO empty, out_valid=0, out_address/out_word=0, error=0, error_count=0, next address=BASE_ADDRESS.
//  Accept: in_valid && in_ready at rising edge. in_ready = !flush && (count < FIFO_DEPTH).
//   No same-cycle pass-through when full.
//  Encoding is combinational on accept; the entry is written at the same edge.
//   out_valid rises the next cycle, so latency is 1 cycle when empty.
//  Pop: out_valid && out_ready. Simultaneous push+pop when full is impossible (in_ready=0).
//   Push+pop otherwise keeps count unchanged. FIFO is strict order; head outputs are stable while stalled.
//  Address: the entry gets next address; next address += 4 per valid push. It wraps mod 2^32.
//  Formats (imm = immediate, f3/f7 = funct3/funct7):
//   R  OP: {f7,rs2,rs1,f3,rd,op}; f7 must be 7'h00, or 7'h20 only with f3 000/101.
//   I  OPIMM/LOAD/JALR: {imm[11:0],rs1,f3,rd,op}; imm must sign-extend from bit 11.
//      OPIMM f3=001/101: {f7,imm[4:0],rs1,f3,rd,op}; imm[31:5]==0.
//      f7 must be 7'h00 for f3=001, and 7'h00 or 7'h20 for f3=101.
//   S  STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],op}; imm sign-extends from bit 11.
//   B  BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
//      imm sign-extends from bit 12, imm[0]==0, f3 must be a branch_cond_t value.
//   U  LUI/AUIPC: {imm[31:12],rd,op}; imm[11:0]==0.
//   J  JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; imm sign-extends from bit 20, imm[0]==0.
//   JALR/LOAD/STORE f3: JALR 000; LOAD 000,001,010,100,101; STORE 000..010.
//  Error: opcode not in opcode_t, or any rule above violated.
//   The instruction is still accepted but not pushed, and the address is not advanced.
//   error=1 in the next cycle; error_count += 1, saturating at 8'hFF.
//  Flush: FIFO cleared and next address reset at the edge; in_ready=0 during flush, so no accept.
//   out_valid=0 the next cycle. error_count is not cleared; a pending error pulse still fires.
//  Async reset mid-stream: all state cleared immediately; no partial entries survive.
// TESTING
//  ADDI x1,x0,5 (imm=5) -> out_word=32'h00500093, out_address=0, out_valid 1 cycle after accept.
//  ADD x3,x1,x2 then SUB (f7=7'h20) -> 32'h002081B3 @0, 32'h402081B3 @4.
//  BEQ x1,x2,imm=8 -> 32'h00208463; JAL x1,imm=2048 -> 32'h001000EF; LUI x5,imm=32'h12345000 -> 32'h123452B7.
//  Errors: ADDI imm=2048, BEQ imm=7, opcode 7'h7F -> each accepted, error pulses, count=3, no push.
//   Next valid instr gets address 0.
//  out_ready=0, push 5 -> in_ready low after 4. Release -> addresses 0,4,8,C in order, then fifth at 10.
//  Flush with 2 entries and in_valid high -> no accept, out_valid=0 next cycle.
//   Next accept gets BASE_ADDRESS. error_count is held.

Source files
------------

// File: rtl/riscv_instruction_encoder_if.sv
// Stream bundle for the RV32I encoder: decoded instructions in, addressed words out.
// The master is the program-loader driver; the slave is the encoder.
interface riscv_instruction_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_address;
  logic [31:0] out_word;
  logic        error;
  logic [7:0]  error_count;

  modport master (
    output in_valid, in_instruction, out_ready,
    input  in_ready, out_valid, out_address, out_word, error, error_count
  );

  modport slave (
    input  in_valid, in_instruction, out_ready,
    output in_ready, out_valid, out_address, out_word, error, error_count
  );
endinterface

// File: rtl/riscv_instruction_encoder.sv
// Packs decoded instructions into RV32I words and queues them with sequential addresses.
// in_instruction layout (MSB..LSB): imm[31:0], funct7, funct3, rs2, rs1, rd, opcode.
module riscv_instruction_encoder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  riscv_instruction_encoder_if.slave   bus
);

  typedef struct packed {
    logic [31:0] imm;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } decoded_instruction_t;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(FIFO_DEPTH);

  decoded_instruction_t ins;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;

  assign ins = bus.in_instruction;
  assign op  = ins.opcode;
  assign rd  = ins.rd;
  assign rs1 = ins.rs1;
  assign rs2 = ins.rs2;
  assign f3  = ins.funct3;
  assign f7  = ins.funct7;
  assign imm = ins.imm;

  logic        sext12, sext13, sext21;
  logic [31:0] i_word;
  logic        legal;
  logic [31:0] enc_word;

  assign sext12 = (imm[31:11] == {21{imm[11]}});
  assign sext13 = (imm[31:12] == {20{imm[12]}});
  assign sext21 = (imm[31:20] == {12{imm[20]}});
  assign i_word = {imm[11:0], rs1, f3, rd, op};

  always_comb begin
    legal    = 1'b0;
    enc_word = '0;
    case (op)
      OpcLui, OpcAuipc: begin
        legal    = (imm[11:0] == 12'h000);
        enc_word = {imm[31:12], rd, op};
      end
      OpcJal: begin
        legal    = sext21 && !imm[0];
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      OpcJalr: begin
        legal    = sext12 && (f3 == 3'b000);
        enc_word = i_word;
      end
      OpcLoad: begin
        legal    = sext12 && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        enc_word = i_word;
      end
      OpcStore: begin
        legal    = sext12 && (f3 inside {3'b000, 3'b001, 3'b010});
        enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      OpcBranch: begin
        // 010/011 are the only funct3 codes with no branch condition
        legal    = sext13 && !imm[0] && !(f3 inside {3'b010, 3'b011});
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      OpcOpImm: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          legal    = (imm[31:5] == 27'd0) &&
                     ((f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20));
          enc_word = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          legal    = sext12;
          enc_word = i_word;
        end
      end
      OpcOp: begin
        legal    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        enc_word = {f7, rs2, rs1, f3, rd, op};
      end
      default: begin
        legal    = 1'b0;
        enc_word = '0;
      end
    endcase
  end

  logic [31:0]     addr_mem_q [FIFO_DEPTH];
  logic [31:0]     word_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [31:0]     next_addr_q;
  logic            error_q;
  logic [7:0]      error_count_q;

  logic accept, push, pop, out_valid;

  assign bus.in_ready = !flush && (count_q != DepthC);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && legal;
  assign out_valid    = (count_q != '0);
  assign pop          = out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      next_addr_q   <= BASE_ADDRESS;
      error_q       <= 1'b0;
      error_count_q <= '0;
    end else begin
      // Error reporting is independent of flush so a pending pulse still fires.
      error_q <= accept && !legal;
      if (accept && !legal && error_count_q != 8'hFF) begin
        error_count_q <= error_count_q + 8'd1;
      end
      if (flush) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        next_addr_q <= BASE_ADDRESS;
      end else begin
        if (push) begin
          wr_ptr_q    <= wr_ptr_q + 1'b1;
          next_addr_q <= next_addr_q + 32'd4;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
          count_q <= count_q + 1'b1;
        end else if (!push && pop) begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      addr_mem_q[wr_ptr_q] <= next_addr_q;
      word_mem_q[wr_ptr_q] <= enc_word;
    end
  end

  assign bus.out_valid   = out_valid;
  assign bus.out_address = out_valid ? addr_mem_q[rd_ptr_q] : '0;
  assign bus.out_word    = out_valid ? word_mem_q[rd_ptr_q] : '0;
  assign bus.error       = error_q;
  assign bus.error_count = error_count_q;

endmodule

// File: tb/tb_riscv_instruction_encoder.sv
// Bench for riscv_instruction_encoder: directed spec cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_riscv_instruction_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  bit   chk_en = 1'b0;

  riscv_instruction_encoder_if bus ();

  riscv_instruction_encoder #(
    .BASE_ADDRESS (BASE),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int n);
    return (v >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  // Reference encoder: field placement by shifting, legality by signed range checks.
  function automatic void ref_encode(input logic [63:0] d, output bit ok, output logic [31:0] w);
    logic [31:0] op, rd, rs1, rs2, f3, f7, u, itype;
    int imm;
    op  = 32'(d[6:0]);
    rd  = 32'(d[11:7]);
    rs1 = 32'(d[16:12]);
    rs2 = 32'(d[21:17]);
    f3  = 32'(d[24:22]);
    f7  = 32'(d[31:25]);
    u   = d[63:32];
    imm = int'($signed(d[63:32]));
    itype = (fld(u, 0, 12) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    ok = 0;
    w  = 0;
    case (op)
      32'h37, 32'h17: begin
        ok = (u % 4096) == 0;
        w  = (u / 4096) * 4096 + rd * 128 + op;
      end
      32'h6F: begin
        ok = imm >= -1048576 && imm <= 1048575 && (imm % 2) == 0;
        w  = (fld(u, 20, 1) << 31) | (fld(u, 1, 10) << 21) | (fld(u, 11, 1) << 20) |
             (fld(u, 12, 8) << 12) | (rd << 7) | op;
      end
      32'h67: begin ok = imm >= -2048 && imm <= 2047 && f3 == 0; w = itype; end
      32'h03: begin
        ok = imm >= -2048 && imm <= 2047 && (f3 <= 2 || f3 == 4 || f3 == 5);
        w  = itype;
      end
      32'h23: begin
        ok = imm >= -2048 && imm <= 2047 && f3 <= 2;
        w  = (fld(u, 5, 7) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
             (fld(u, 0, 5) << 7) | op;
      end
      32'h63: begin
        ok = imm >= -4096 && imm <= 4095 && (imm % 2) == 0 && f3 != 2 && f3 != 3;
        w  = (fld(u, 12, 1) << 31) | (fld(u, 5, 6) << 25) | (rs2 << 20) | (rs1 << 15) |
             (f3 << 12) | (fld(u, 1, 4) << 8) | (fld(u, 11, 1) << 7) | op;
      end
      32'h13: begin
        if (f3 == 1 || f3 == 5) begin
          ok = u < 32 && (f7 == 0 || (f3 == 5 && f7 == 32));
          w  = (f7 << 25) | (fld(u, 0, 5) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        end else begin
          ok = imm >= -2048 && imm <= 2047;
          w  = itype;
        end
      end
      32'h33: begin
        ok = f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5));
        w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      default: begin ok = 0; w = 0; end
    endcase
  endfunction

  function automatic logic [63:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm);
    return {imm, f7, f3, rs2, rs1, rd, op};
  endfunction

  function automatic logic [63:0] rand_instr();
    logic [6:0]  ops [9];
    logic [6:0]  op, f7;
    logic [31:0] imm;
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    op  = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1:       imm = $urandom & 32'hFFFF_F000;
      2:       imm = 32'($urandom_range(0, 31));
      3:       imm = $urandom;
      4:       imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      default: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
    endcase
    return mk(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), f7, imm);
  endfunction

  // Behavioural model: queue of {address, word}.
  logic [63:0] m_q [$];
  logic [31:0] m_next;
  logic        m_err;
  logic [7:0]  m_cnt;

  always @(posedge clk or negedge rst_n) begin
    bit          ok, acc, rdy;
    logic [31:0] w;
    if (!rst_n) begin
      m_q.delete();
      m_next <= BASE;
      m_err  <= 1'b0;
      m_cnt  <= 8'd0;
    end else begin
      rdy = !flush && (m_q.size() < DEPTH);
      acc = bus.in_valid && rdy;
      ref_encode(bus.in_instruction, ok, w);
      if (flush) begin
        m_q.delete();
        m_next <= BASE;
      end else begin
        if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
        if (acc && ok) begin
          m_q.push_back({m_next, w});
          m_next <= m_next + 32'd4;
        end
      end
      m_err <= acc && !ok;
      if (acc && !ok && m_cnt != 8'd255) m_cnt <= m_cnt + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("in_ready", 32'(bus.in_ready), 32'(!flush && (m_q.size() < DEPTH)));
      check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("out_address", bus.out_address, m_q[0][63:32]);
        check("out_word", bus.out_word, m_q[0][31:0]);
      end
      check("error", 32'(bus.error), 32'(m_err));
      check("error_count", 32'(bus.error_count), 32'(m_cnt));
    end
  end

  task automatic cyc(input logic v, input logic [63:0] ins, input logic rdy, input logic fl);
    bus.in_valid       = v;
    bus.in_instruction = ins;
    bus.out_ready      = rdy;
    flush              = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input string name, input logic [63:0] d, input bit exp_ok,
                     input logic [31:0] exp_w);
    bit          ok;
    logic [31:0] w;
    ref_encode(d, ok, w);
    check({name, "_ok"}, 32'(ok), 32'(exp_ok));
    if (exp_ok) check({name, "_word"}, w, exp_w);
  endtask

  logic [63:0] addi5, add3, sub3, beq8, jal2k, lui5, err_addi, err_beq, err_op, fifth;

  initial begin
    addi5    = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
    add3     = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
    sub3     = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    beq8     = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8);
    jal2k    = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
    lui5     = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
    err_addi = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
    err_beq  = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd7);
    err_op   = mk(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    fifth    = mk(7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9);

    bus.in_valid = 0; bus.in_instruction = '0; bus.out_ready = 0; flush = 0;

    // Model pinned to hand-computed encodings.
    pin("m_addi", addi5, 1, 32'h00500093);
    pin("m_add", add3, 1, 32'h002081B3);
    pin("m_sub", sub3, 1, 32'h402081B3);
    pin("m_beq", beq8, 1, 32'h00208463);
    pin("m_jal", jal2k, 1, 32'h001000EF);
    pin("m_lui", lui5, 1, 32'h123452B7);
    pin("m_err_addi", err_addi, 0, 32'h0);
    pin("m_err_beq", err_beq, 0, 32'h0);
    pin("m_err_op", err_op, 0, 32'h0);

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_word", bus.out_word, 32'd0);
    check("rst_out_address", bus.out_address, 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_error_count", 32'(bus.error_count), 32'd0);
    @(posedge clk); #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // ADDI, latency 1.
    cyc(1, addi5, 0, 0);
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_word", bus.out_word, 32'h00500093);
    check("addi_addr", bus.out_address, 32'h0);
    cyc(0, '0, 1, 0);

    // ADD then SUB from a fresh address.
    cyc(0, '0, 0, 1);
    cyc(1, add3, 0, 0);
    cyc(1, sub3, 0, 0);
    check("add_word", bus.out_word, 32'h002081B3);
    check("add_addr", bus.out_address, 32'h0);
    cyc(0, '0, 1, 0);
    check("sub_word", bus.out_word, 32'h402081B3);
    check("sub_addr", bus.out_address, 32'h4);
    cyc(0, '0, 1, 0);
    cyc(1, beq8, 1, 0);
    check("beq_word", bus.out_word, 32'h00208463);
    cyc(1, jal2k, 1, 0);
    check("jal_word", bus.out_word, 32'h001000EF);
    cyc(1, lui5, 1, 0);
    check("lui_word", bus.out_word, 32'h123452B7);
    cyc(0, '0, 1, 0);

    // Unencodable instructions.
    cyc(0, '0, 1, 1);
    cyc(1, err_addi, 1, 0);
    check("err1_pulse", 32'(bus.error), 32'd1);
    cyc(1, err_beq, 1, 0);
    check("err2_pulse", 32'(bus.error), 32'd1);
    cyc(1, err_op, 1, 0);
    check("err3_pulse", 32'(bus.error), 32'd1);
    check("err_count3", 32'(bus.error_count), 32'd3);
    check("err_no_push", 32'(bus.out_valid), 32'd0);
    cyc(1, addi5, 0, 0);
    check("err_clear", 32'(bus.error), 32'd0);
    check("after_err_addr", bus.out_address, 32'h0);
    cyc(0, '0, 1, 0);

    // Fill while stalled.
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, mk(7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'h00, 32'(i)), 0, 0);
    cyc(1, fifth, 0, 0);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    cyc(1, fifth, 0, 0);
    check("full_ready2", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_addr", bus.out_address, 32'(4 * i));
      cyc(0, '0, 1, 0);
    end
    cyc(1, fifth, 0, 0);
    check("fifth_addr", bus.out_address, 32'h10);
    cyc(0, '0, 1, 0);

    // Flush with entries present and in_valid high.
    cyc(1, add3, 0, 0);
    cyc(1, sub3, 0, 0);
    check("pre_flush_valid", 32'(bus.out_valid), 32'd1);
    cyc(1, beq8, 0, 1);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_count_held", 32'(bus.error_count), 32'd3);
    cyc(1, addi5, 0, 0);
    check("post_flush_addr", bus.out_address, BASE);
    check("post_flush_word", bus.out_word, 32'h00500093);
    cyc(0, '0, 1, 0);

    // Error pulse still fires across a flush; count saturates.
    cyc(1, err_op, 1, 0);
    cyc(0, '0, 1, 1);
    for (int i = 0; i < 300; i++) cyc(1, err_op, 1, 0);
    check("err_saturate", 32'(bus.error_count), 32'hFF);
    cyc(0, '0, 1, 0);

    // Asynchronous reset mid-stream.
    cyc(1, add3, 0, 0);
    cyc(1, sub3, 0, 0);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_word", bus.out_word, 32'd0);
    check("arst_count", 32'(bus.error_count), 32'd0);
    bus.in_valid = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, rand_instr(),
          ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end
    cyc(0, '0, 1, 0);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
